// File: rtl/usb_pkg.sv
`default_nettype none
// ============================================================================
// usb_pkg - shared USB 1.1 packet types, PID/SYNC/CRC bytes and line constants
// Revision: 1.0
// ============================================================================
package usb_pkg;

    typedef enum logic [2:0] {
        TX_NONE  = 3'd0,
        TX_DATA0 = 3'd1,
        TX_DATA1 = 3'd2,
        TX_ACK   = 3'd3,
        TX_NAK   = 3'd4,
        TX_STALL = 3'd5
    } tx_packet_t;

    localparam logic [7:0] SYNC_BYTE = 8'h80;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;
    localparam logic [7:0] PID_STALL = 8'h1E;
    localparam logic [7:0] CRC1_BYTE = 8'hAA;
    localparam logic [7:0] CRC2_BYTE = 8'h55;

    // Line states as {dplus, dminus}
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    function automatic logic pkt_valid(input logic [2:0] p);
        return (p != 3'd0) && (p <= 3'd5);
    endfunction

    function automatic logic is_handshake(input tx_packet_t p);
        return (p == TX_ACK) || (p == TX_NAK) || (p == TX_STALL);
    endfunction

    function automatic logic [7:0] pid_byte(input tx_packet_t p);
        logic [7:0] pid;
        case (p)
            TX_DATA0: pid = PID_DATA0;
            TX_DATA1: pid = PID_DATA1;
            TX_ACK:   pid = PID_ACK;
            TX_NAK:   pid = PID_NAK;
            TX_STALL: pid = PID_STALL;
            default:  pid = 8'h00;
        endcase
        return pid;
    endfunction

endpackage
`default_nettype wire

// File: rtl/usb_tx_encoder.sv
`default_nettype none
// ============================================================================
// usb_tx_encoder - bit timer, bit stuffer and NRZI line driver
// Revision: 1.0
// ============================================================================
module usb_tx_encoder
    import usb_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic tx_bit,
    input  logic bit_valid,
    input  logic se0,
    input  logic eop_clear,
    output logic bit_ready,
    output logic dplus,
    output logic dminus
);

    localparam int            TW    = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] T_MAX = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] timer;
    logic [2:0]    ones;
    logic          level;
    logic          active;
    logic          strobe;
    logic          stuff;

    // The idle timer parks at T_MAX so the first request is launched on the next edge.
    assign active    = bit_valid | se0 | eop_clear;
    assign strobe    = active && (timer == T_MAX);
    assign stuff     = (ones == 3'd6);
    // Ticks for SE0/J bit times too, which lets the controller time the EOP.
    assign bit_ready = strobe && !stuff;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            timer            <= T_MAX;
            ones             <= 3'd0;
            level            <= 1'b1;
            {dplus, dminus}  <= LINE_J;
        end else begin
            if (!active || timer == T_MAX) begin
                timer <= active ? '0 : T_MAX;
            end else begin
                timer <= timer + 1'b1;
            end

            if (strobe) begin
                if (stuff) begin
                    level           <= ~level;
                    {dplus, dminus} <= level ? LINE_K : LINE_J;
                    ones            <= 3'd0;
                end else if (eop_clear) begin
                    level           <= 1'b1;
                    {dplus, dminus} <= LINE_J;
                    ones            <= 3'd0;
                end else if (se0) begin
                    {dplus, dminus} <= LINE_SE0;
                    ones            <= 3'd0;
                end else if (tx_bit) begin
                    {dplus, dminus} <= level ? LINE_J : LINE_K;
                    ones            <= ones + 3'd1;
                end else begin
                    level           <= ~level;
                    {dplus, dminus} <= level ? LINE_K : LINE_J;
                    ones            <= 3'd0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/usb_tx_ctrl.sv
`default_nettype none
// ============================================================================
// usb_tx_ctrl - USB 1.1 full-speed packet transmitter: framing FSM and byte shifter
// Revision: 1.0
// ============================================================================
module usb_tx_ctrl
    import usb_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       TX_Start,
    input  logic [2:0] TX_Packet,
    input  logic [7:0] fifo_data,
    input  logic       fifo_empty,
    output logic       r_en,
    output logic       dplus,
    output logic       dminus,
    output logic       TX_Transfer_Active,
    output logic       TX_Done,
    output logic       TX_Error
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        LOAD_SYNC = 4'd1,
        SEND_SYNC = 4'd2,
        LOAD_PID  = 4'd3,
        SEND_PID  = 4'd4,
        LOAD_DATA = 4'd5,
        SEND_DATA = 4'd6,
        LOAD_CRC1 = 4'd7,
        SEND_CRC1 = 4'd8,
        LOAD_CRC2 = 4'd9,
        SEND_CRC2 = 4'd10,
        EOP_SE0   = 4'd11,
        EOP_J     = 4'd12,
        DONE      = 4'd13,
        ERR       = 4'd14
    } state_t;

    state_t     state;
    tx_packet_t pkt;
    logic [7:0] shreg;
    logic [2:0] bit_cnt;
    logic       bit_ready;
    logic       bit_valid;
    logic       se0;
    logic       eop_clear;
    logic       last_bit;

    // LOAD states keep the timer running so the next byte follows without a gap.
    always_comb begin
        bit_valid = 1'b0;
        se0       = 1'b0;
        eop_clear = 1'b0;
        case (state)
            SEND_SYNC, LOAD_PID, SEND_PID, LOAD_DATA, SEND_DATA,
            LOAD_CRC1, SEND_CRC1, LOAD_CRC2, SEND_CRC2: bit_valid = 1'b1;
            EOP_SE0: se0       = 1'b1;
            EOP_J:   eop_clear = 1'b1;
            default: ;
        endcase
    end

    assign last_bit = bit_ready && (bit_cnt == 3'd7);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state              <= IDLE;
            pkt                <= TX_NONE;
            shreg              <= 8'h00;
            bit_cnt            <= 3'd0;
            r_en               <= 1'b0;
            TX_Transfer_Active <= 1'b0;
            TX_Done            <= 1'b0;
            TX_Error           <= 1'b0;
        end else begin
            r_en     <= 1'b0;
            TX_Done  <= 1'b0;
            TX_Error <= 1'b0;

            if (bit_ready && bit_valid) begin
                shreg   <= {1'b0, shreg[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end

            case (state)
                IDLE: begin
                    if (TX_Start) begin
                        if (pkt_valid(TX_Packet)) begin
                            pkt   <= tx_packet_t'(TX_Packet);
                            state <= LOAD_SYNC;
                        end else begin
                            TX_Error <= 1'b1;
                            state    <= ERR;
                        end
                    end
                end
                ERR: state <= IDLE;
                LOAD_SYNC: begin
                    shreg   <= SYNC_BYTE;
                    bit_cnt <= 3'd0;
                    state   <= SEND_SYNC;
                end
                SEND_SYNC: begin
                    TX_Transfer_Active <= 1'b1;
                    if (last_bit) state <= LOAD_PID;
                end
                LOAD_PID: begin
                    shreg <= pid_byte(pkt);
                    state <= SEND_PID;
                end
                SEND_PID: begin
                    if (last_bit) begin
                        if (is_handshake(pkt)) begin
                            state <= EOP_SE0;
                        end else if (!fifo_empty) begin
                            r_en  <= 1'b1;
                            state <= LOAD_DATA;
                        end else begin
                            state <= LOAD_CRC1;
                        end
                    end
                end
                LOAD_DATA: begin
                    shreg <= fifo_data;
                    state <= SEND_DATA;
                end
                SEND_DATA: begin
                    if (last_bit) begin
                        if (!fifo_empty) begin
                            r_en  <= 1'b1;
                            state <= LOAD_DATA;
                        end else begin
                            state <= LOAD_CRC1;
                        end
                    end
                end
                LOAD_CRC1: begin
                    shreg <= CRC1_BYTE;
                    state <= SEND_CRC1;
                end
                SEND_CRC1: if (last_bit) state <= LOAD_CRC2;
                LOAD_CRC2: begin
                    shreg <= CRC2_BYTE;
                    state <= SEND_CRC2;
                end
                SEND_CRC2: if (last_bit) state <= EOP_SE0;
                // bit_cnt has wrapped to 0 on entry; it counts the two SE0 ticks.
                EOP_SE0: begin
                    if (bit_ready) begin
                        if (bit_cnt == 3'd1) begin
                            bit_cnt <= 3'd0;
                            state   <= EOP_J;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
                // Second tick marks the end of the J bit time.
                EOP_J: begin
                    if (bit_ready) begin
                        if (bit_cnt == 3'd1) begin
                            TX_Done            <= 1'b1;
                            TX_Transfer_Active <= 1'b0;
                            state              <= DONE;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    usb_tx_encoder #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_encoder (
        .clk      (clk),
        .n_rst    (n_rst),
        .tx_bit   (shreg[0]),
        .bit_valid(bit_valid),
        .se0      (se0),
        .eop_clear(eop_clear),
        .bit_ready(bit_ready),
        .dplus    (dplus),
        .dminus   (dminus)
    );

endmodule
`default_nettype wire

// File: tb/tb_usb_tx_ctrl.sv
`default_nettype none
// ============================================================================
// tb_usb_tx_ctrl - directed vectors for usb_tx_ctrl framing, NRZI, stuffing, EOP
// Revision: 1.0
// ============================================================================
module tb_usb_tx_ctrl;

    localparam int CPB = 8;

    typedef struct {
        logic [2:0]  pkt;
        int          nbytes;
        logic [23:0] data;       // byte 0 in [7:0]
        int          nbits;      // hand-computed bits before EOP, stuffing included
        int          nren;
        bit          err;
        int          restart_at; // cycle of an extra TX_Start, 0 = none
    } vec_t;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       TX_Start = 1'b0;
    logic [2:0] TX_Packet = 3'd0;
    logic [7:0] fifo_data;
    logic       fifo_empty;
    logic       r_en, dplus, dminus, act, done, err;

    logic [7:0] fmem [0:7];
    logic [2:0] rd_ptr = 3'd0;
    logic [2:0] wr_ptr = 3'd0;
    int         ren_total = 0;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [1:0] exp_sym [0:127];
    int         exp_len;
    vec_t       vecs [0:9];

    always #5 clk = ~clk;

    assign fifo_data  = fmem[rd_ptr];
    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (r_en) begin
            rd_ptr    <= rd_ptr + 3'd1;
            ren_total <= ren_total + 1;
        end
    end

    usb_tx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
        .clk               (clk),
        .n_rst             (n_rst),
        .TX_Start          (TX_Start),
        .TX_Packet         (TX_Packet),
        .fifo_data         (fifo_data),
        .fifo_empty        (fifo_empty),
        .r_en              (r_en),
        .dplus             (dplus),
        .dminus            (dminus),
        .TX_Transfer_Active(act),
        .TX_Done           (done),
        .TX_Error          (err)
    );

    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic push_sym(input logic [1:0] s);
        exp_sym[exp_len] = s;
        exp_len++;
    endtask

    // Expected line symbols: bytes LSB first, stuff after six 1s, NRZI from J, then SE0 SE0 J.
    task automatic build_model(input vec_t v);
        logic [7:0] bytes [0:7];
        int         nb;
        int         ones;
        logic       lvl;
        logic       b;
        logic [7:0] pid;
        case (v.pkt)
            3'd1:    pid = 8'hC3;
            3'd2:    pid = 8'h4B;
            3'd3:    pid = 8'hD2;
            3'd4:    pid = 8'h5A;
            default: pid = 8'h1E;
        endcase
        bytes[0] = 8'h80;
        bytes[1] = pid;
        nb = 2;
        if (v.pkt == 3'd1 || v.pkt == 3'd2) begin
            for (int i = 0; i < v.nbytes; i++) begin
                bytes[nb] = v.data[8*i +: 8];
                nb = nb + 1;
            end
            bytes[nb]   = 8'hAA;
            bytes[nb+1] = 8'h55;
            nb = nb + 2;
        end
        exp_len = 0;
        ones    = 0;
        lvl     = 1'b1;
        for (int i = 0; i < nb; i++) begin
            for (int k = 0; k < 8; k++) begin
                if (ones == 6) begin
                    lvl  = ~lvl;
                    ones = 0;
                    push_sym(lvl ? 2'b10 : 2'b01);
                end
                b = bytes[i][k];
                if (b) ones = ones + 1;
                else begin
                    ones = 0;
                    lvl  = ~lvl;
                end
                push_sym(lvl ? 2'b10 : 2'b01);
            end
        end
        if (ones == 6) begin
            lvl = ~lvl;
            push_sym(lvl ? 2'b10 : 2'b01);
        end
        push_sym(2'b00);
        push_sym(2'b00);
        push_sym(2'b10);
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int         win, line_bad, done_cnt, done_idx, act_cnt, act_first;
        int         err_cnt, err_idx, ren0, bi;
        logic [1:0] want;
        wr_ptr = rd_ptr;
        for (int i = 0; i < v.nbytes; i++) begin
            fmem[wr_ptr] = v.data[8*i +: 8];
            wr_ptr = wr_ptr + 3'd1;
        end
        build_model(v);
        ren0 = ren_total;
        @(negedge clk);
        TX_Packet = v.pkt;
        TX_Start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        TX_Start  = 1'b0;
        win       = v.err ? 40 : 2 + (v.nbits + 6) * CPB;
        line_bad  = -1; done_cnt = 0; done_idx = -1; act_cnt = 0;
        act_first = -1; err_cnt = 0;  err_idx  = -1;
        for (int c = 0; c < win; c++) begin
            if (c > 0) @(negedge clk);
            want = 2'b10;
            if (!v.err && c >= 2) begin
                bi = (c - 2) / CPB;
                if (bi < exp_len) want = exp_sym[bi];
            end
            if ({dplus, dminus} !== want && line_bad < 0) line_bad = c;
            if (done) begin
                done_cnt++;
                if (done_idx < 0) done_idx = c;
            end
            if (act) begin
                act_cnt++;
                if (act_first < 0) act_first = c;
            end
            if (err) begin
                err_cnt++;
                if (err_idx < 0) err_idx = c;
            end
            TX_Start = (v.restart_at > 0) && (c == v.restart_at);
        end
        TX_Start = 1'b0;
        check({nm, " line_first_bad_cycle"}, line_bad, -1);
        check({nm, " done_count"}, done_cnt, v.err ? 0 : 1);
        check({nm, " active_cycles"}, act_cnt, v.err ? 0 : (v.nbits + 3) * CPB);
        check({nm, " r_en_count"}, ren_total - ren0, v.nren);
        check({nm, " error_count"}, err_cnt, v.err ? 1 : 0);
        if (v.err) begin
            check({nm, " error_cycle"}, err_idx, 0);
        end else begin
            check({nm, " done_cycle"}, done_idx, 2 + (v.nbits + 3) * CPB);
            check({nm, " active_first"}, act_first, 2);
        end
    endtask

    initial begin
        vecs[0] = '{3'd3, 0, 24'h0,      16, 0, 1'b0, 0};
        vecs[1] = '{3'd4, 0, 24'h0,      16, 0, 1'b0, 0};
        vecs[2] = '{3'd5, 0, 24'h0,      16, 0, 1'b0, 0};
        vecs[3] = '{3'd1, 1, 24'h0000FF, 41, 1, 1'b0, 0};
        vecs[4] = '{3'd2, 0, 24'h0,      32, 0, 1'b0, 0};
        vecs[5] = '{3'd1, 1, 24'h0000A5, 40, 1, 1'b0, 0};
        vecs[6] = '{3'd2, 3, 24'hFF7E00, 58, 3, 1'b0, 150};
        vecs[7] = '{3'd6, 0, 24'h0,       0, 0, 1'b1, 0};
        vecs[8] = '{3'd0, 0, 24'h0,       0, 0, 1'b1, 0};
        vecs[9] = '{3'd7, 0, 24'h0,       0, 0, 1'b1, 0};
        for (int i = 0; i < 8; i++) fmem[i] = 8'h00;

        repeat (3) @(negedge clk);
        check("reset outputs {dp,dm,act,done,err,ren}",
              int'({dplus, dminus, act, done, err, r_en}), int'(6'b100000));
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            repeat (3) @(negedge clk);
        end

        // Abort a DATA0 packet in its second payload byte.
        wr_ptr = rd_ptr;
        fmem[wr_ptr] = 8'hA5; wr_ptr = wr_ptr + 3'd1;
        fmem[wr_ptr] = 8'hFF; wr_ptr = wr_ptr + 3'd1;
        fmem[wr_ptr] = 8'h00; wr_ptr = wr_ptr + 3'd1;
        begin
            int ren0;
            ren0 = ren_total;
            @(negedge clk);
            TX_Packet = 3'd1;
            TX_Start  = 1'b1;
            @(posedge clk);
            @(negedge clk);
            TX_Start  = 1'b0;
            repeat (200) @(negedge clk);
            check("abort r_en_count_before_reset", ren_total - ren0, 2);
        end
        #2 n_rst = 1'b0;
        #1;
        check("abort line_during_reset", int'({dplus, dminus}), 2);
        check("abort active_during_reset", int'(act), 0);
        @(negedge clk);
        n_rst  = 1'b1;
        wr_ptr = rd_ptr;
        repeat (4) @(negedge clk);
        check("abort idle_after_release {dp,dm,act}", int'({dplus, dminus, act}), int'(3'b100));
        run_vec(vecs[0], "after_reset_ack");
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
